seq_divider: RTL and testbench

Iterative unsigned 32-bit restoring divider for the ALU datapath. Each cycle it computes one quotient bit by trial subtraction, which is the inverse of the ripple adder's addition. The trial subtract is built as a + ~b + 1, with carry-out meaning "no borrow", so the existing 32-bit `Adder` is instantiated with cin=1. The divider sits beside the adder as the multi-cycle divide/remainder unit and uses a start/busy/done handshake.

---
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 120 ++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per cycle,
// trial subtraction done by the shared ripple Adder with cin=1.
module Adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             overflow_o
);
   assign {overflow_o, sum_o} = a_i + b_i + {{WIDTH{1'b0}}, cin_i};
endmodule

module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dz_q, dz_d;
   logic             busy_q, done_q, dbz_q;
   logic [WIDTH-1:0] quo_q, rem_q;
   logic [WIDTH:0]   rs;
   logic [WIDTH-1:0] sum;
   logic             c, acc;
   assign rs  = {r_q, q_q[WIDTH-1]};
   assign acc = rs[WIDTH] | c;
   Adder #(.WIDTH(WIDTH)) u_sub (
      .a_i       (rs[WIDTH-1:0]),
      .b_i       (~d_q),
      .cin_i     (1'b1),
      .sum_o     (sum),
      .overflow_o(c)
   );
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: if (start_i) begin
            d_d     = divisor_i;
            q_d     = dividend_i;
            r_d     = '0;
            cnt_d   = '0;
            dz_d    = divisor_i == '0;
            state_d = divisor_i == '0 ? FINISH : RUN;
         end
         RUN: begin
            r_d     = acc ? sum : rs[WIDTH-1:0];
            q_d     = {q_q[WIDTH-2:0], acc};
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(WIDTH-1) ? FINISH : RUN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         busy_q  <= state_d != IDLE;
         done_q  <= state_q == FINISH;
         if (state_q == FINISH) begin
            // on divide-by-zero q still holds the untouched dividend
            quo_q <= dz_q ? '1 : q_q;
            rem_q <= dz_q ? q_q : r_q;
            dbz_q <= dz_q;
         end
      end
   end
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign quotient_o    = quo_q;
   assign remainder_o   = rem_q;
   assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider with hand-computed results.
module tb_seq_divider;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [31:0] dividend_i, divisor_i;
   logic        busy_o, done_o, div_by_zero_o;
   logic [31:0] quotient_o, remainder_o;
   int          n_tests = 0;
   int          n_fail = 0;

   seq_divider dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .dividend_i   (dividend_i),
      .divisor_i    (divisor_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .quotient_o   (quotient_o),
      .remainder_o  (remainder_o),
      .div_by_zero_o(div_by_zero_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // poke >= 0 pulses start with 1/1 at that cycle index of the run
   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat, input int poke);
      int n = 0;
      int bc = 0;
      int both = 0;
      start_i = 1'b1; dividend_i = a; divisor_i = b;
      tick();
      start_i = 1'b0;
      while (!done_o && n < 40) begin
         if (busy_o) bc++;
         if (busy_o && done_o) both++;
         start_i = n == poke;
         if (n == poke) begin dividend_i = 32'd1; divisor_i = 32'd1; end
         tick();
         start_i = 1'b0;
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(elat));
      check({tag, "_busycyc"}, 32'(bc), 32'(elat));
      check({tag, "_busy_at_done"}, {31'd0, busy_o}, 32'd0);
      check({tag, "_overlap"}, 32'(both), 32'd0);
      check({tag, "_quo"}, quotient_o, eq);
      check({tag, "_rem"}, remainder_o, er);
      check({tag, "_dz"}, {31'd0, div_by_zero_o}, {31'd0, edz});
   endtask

   initial begin
      int dn;
      rst_n = 1'b0; start_i = 1'b0; dividend_i = '0; divisor_i = '0;
      tick(); tick();
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_quo", quotient_o, 32'd0);
      check("rst_rem", remainder_o, 32'd0);
      rst_n = 1'b1;
      tick();

      do_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, -1);
      tick();
      check("done_pulse", {31'd0, done_o}, 32'd0);
      check("hold_quo", quotient_o, 32'd14);
      do_div("msb", 32'hFFFF_FFFE, 32'h8000_0001, 32'd1, 32'h7FFF_FFFD, 1'b0, 33, -1);
      do_div("ff_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, -1);
      do_div("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33, -1);
      tick();
      do_div("dz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, -1);
      tick();
      check("dz_hold", {31'd0, div_by_zero_o}, 32'd1);
      do_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, -1);
      tick();
      do_div("ignore", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 9);
      do_div("b2b", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, -1);
      tick();

      start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      check("mid_rst_done", {31'd0, done_o}, 32'd0);
      check("mid_rst_quo", quotient_o, 32'd0);
      check("mid_rst_rem", remainder_o, 32'd0);
      check("mid_rst_dz", {31'd0, div_by_zero_o}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o || busy_o) dn++;
         tick();
      end
      check("no_done_after_rst", 32'(dn), 32'd0);
      do_div("post_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
